// File: rtl/fifo_tx_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_tx_controller: gates IFFT samples into a TX FIFO and drains them    |
// | frame-by-frame to the transmitter.                 Revision: 1.0         |
// +--------------------------------------------------------------------------+
module fifo_tx_controller #(
  parameter int FRAME_LEN = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic ifft_valid_i,
  input  logic ifft_last_i,
  output logic ifft_ready_o,
  output logic fifo_wr_en_o,
  output logic fifo_rd_en_o,
  input  logic tx_ready_i,
  output logic tx_valid_o,
  output logic tx_last_o,
  output logic frame_done_o,
  output logic frame_err_o
);

  localparam logic [10:0] C_LEN      = 11'(FRAME_LEN);
  localparam logic [10:0] C_LAST_IDX = 11'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] wr_cnt_q, wr_cnt_d;
  logic [10:0] rd_cnt_q, rd_cnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic        err_q, err_d;
  logic        w_ready, w_wr_en, w_rd_en, w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    err_d      = err_q;
    tx_last_d  = 1'b0;
    w_ready    = 1'b0;
    w_wr_en    = 1'b0;
    w_rd_en    = 1'b0;
    w_done     = 1'b0;
    case (state_q)
      ST_FILL: begin
        w_ready = ~reset;
        w_wr_en = ifft_valid_i & w_ready;
        if (w_wr_en) begin
          wr_cnt_d = wr_cnt_q + 11'd1;
          // ifft_last must mark exactly the final write; only the count ends a frame
          if (ifft_last_i != (wr_cnt_q == C_LAST_IDX)) err_d = 1'b1;
          if (wr_cnt_q == C_LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_rd_en = tx_ready_i & (rd_cnt_q < C_LEN) & ~reset;
        if (w_rd_en) begin
          rd_cnt_d  = rd_cnt_q + 11'd1;
          tx_last_d = (rd_cnt_q == C_LAST_IDX);
          if (rd_cnt_q == C_LAST_IDX) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_done   = ~reset;
        state_d  = ST_FILL;
        wr_cnt_d = '0;
        rd_cnt_d = '0;
      end
      default: state_d = ST_FILL;
    endcase
    tx_valid_d = w_rd_en;
  end

  // Registered outputs are masked so every output reads zero throughout reset
  assign ifft_ready_o = w_ready;
  assign fifo_wr_en_o = w_wr_en;
  assign fifo_rd_en_o = w_rd_en;
  assign tx_valid_o   = tx_valid_q & ~reset;
  assign tx_last_o    = tx_last_q & ~reset;
  assign frame_done_o = w_done;
  assign frame_err_o  = err_q & ~reset;

endmodule
`default_nettype wire
